// File: rtl/qpimem_target.sv
// qpimem_target: QPI PSRAM target that behaves like an ly68l6400 at the bus pins.
//
// The QPI bus is oversampled on clk: spi_clk is treated as data and is never
// used as a clock. Quad read (READCMD) and quad write (WRITECMD) are served
// from a byte-wide synchronous memory port with a read latency of one clk.
//
// Ports:
//   clk        system clock, sole clock of the block (>= 8x spi_clk)
//   rst        synchronous reset, active-high
//   spi_clk    QPI bus clock from the initiator (sampled)
//   spi_ncs    chip select, active-low
//   spi_sin    bus nibble driven by the initiator
//   spi_sout   nibble driven by this block during the read data phase
//   spi_oe     output enable for spi_sout
//   mem_addr   backing memory byte address
//   mem_wdata  write byte
//   mem_we     one-cycle write strobe
//   mem_re     one-cycle read strobe
//   mem_rdata  read byte, valid exactly one clk after mem_re
//   busy       high while the synchronized chip select is low
//   bad_cmd    one-cycle pulse on an unrecognized opcode
module qpimem_target #(
  parameter logic [7:0] READCMD    = 8'hEB,
  parameter logic [7:0] WRITECMD   = 8'h38,
  parameter int         READDUMMY  = 7,
  parameter int         WRITEDUMMY = 0,
  parameter int         MEM_AW     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_ncs,
  input  logic [3:0]        spi_sin,
  output logic [3:0]        spi_sout,
  output logic              spi_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              bad_cmd
);

  localparam logic [7:0] RD_DUMMY = 8'(READDUMMY);
  localparam logic [7:0] WR_DUMMY = 8'(WRITEDUMMY);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Bus synchronizers and edge detection. All three bus inputs see the same
  // two-flop delay so a nibble and the clock edge that qualifies it stay aligned.
  // ---------------------------------------------------------------------------
  logic       clk_meta, clk_s, clk_prev;
  logic       ncs_meta, ncs_s;
  logic [3:0] sin_meta, sin_s;
  logic       rise, fall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would turn the two-flop chain into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta <= 1'b0;
      clk_s    <= 1'b0;
      clk_prev <= 1'b0;
      ncs_meta <= 1'b1;
      ncs_s    <= 1'b1;
      sin_meta <= '0;
      sin_s    <= '0;
    end else begin
      clk_meta <= spi_clk;
      clk_s    <= clk_meta;
      clk_prev <= clk_s;
      ncs_meta <= spi_ncs;
      ncs_s    <= ncs_meta;
      sin_meta <= spi_sin;
      sin_s    <= sin_meta;
    end
  end

  assign rise = clk_s & ~clk_prev;
  assign fall = ~clk_s & clk_prev;
  assign busy = ~ncs_s;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;          // nibble / dummy counter
  logic [3:0]        op_hi_q, op_hi_d;      // opcode[7:4]
  logic              is_read_q, is_read_d;
  logic [MEM_AW-1:0] addr_q, addr_d;        // address shifter, then byte pointer
  logic [7:0]        prefetch_q, prefetch_d;
  logic              fetch_wait_q, fetch_wait_d;
  logic [3:0]        cur_lo_q, cur_lo_d;    // low nibble of the byte on the bus
  logic              lo_next_q, lo_next_d;
  logic [3:0]        wr_hi_q, wr_hi_d;
  logic              wr_lo_q, wr_lo_d;      // next write nibble is the low one
  logic [3:0]        sout_d;
  logic              oe_d, mem_we_d, mem_re_d, bad_cmd_d;
  logic [MEM_AW-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic [7:0]        dummy_n;
  logic [MEM_AW-1:0] addr_full;
  logic [7:0]        opcode;

  assign dummy_n   = is_read_q ? RD_DUMMY : WR_DUMMY;
  // Shifting into an MEM_AW-wide register truncates the 24-bit bus address.
  assign addr_full = {addr_q[MEM_AW-5:0], sin_s};
  assign opcode    = {op_hi_q, sin_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_hi_q      <= '0;
      is_read_q    <= 1'b0;
      addr_q       <= '0;
      prefetch_q   <= '0;
      fetch_wait_q <= 1'b0;
      cur_lo_q     <= '0;
      lo_next_q    <= 1'b0;
      wr_hi_q      <= '0;
      wr_lo_q      <= 1'b0;
      spi_sout     <= '0;
      spi_oe       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      bad_cmd      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_hi_q      <= op_hi_d;
      is_read_q    <= is_read_d;
      addr_q       <= addr_d;
      prefetch_q   <= prefetch_d;
      fetch_wait_q <= fetch_wait_d;
      cur_lo_q     <= cur_lo_d;
      lo_next_q    <= lo_next_d;
      wr_hi_q      <= wr_hi_d;
      wr_lo_q      <= wr_lo_d;
      spi_sout     <= sout_d;
      spi_oe       <= oe_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_we       <= mem_we_d;
      mem_re       <= mem_re_d;
      bad_cmd      <= bad_cmd_d;
    end
  end

  // NOTE: every signal written below gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_hi_d     = op_hi_q;
    is_read_d   = is_read_q;
    addr_d      = addr_q;
    cur_lo_d    = cur_lo_q;
    lo_next_d   = lo_next_q;
    wr_hi_d     = wr_hi_q;
    wr_lo_d     = wr_lo_q;
    sout_d      = spi_sout;
    oe_d        = spi_oe;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    bad_cmd_d   = 1'b0;

    // Memory read data arrives one clk after mem_re; capture it the clk after.
    fetch_wait_d = mem_re;
    prefetch_d   = fetch_wait_q ? mem_rdata : prefetch_q;

    if (ncs_s) begin
      // Deselect wins over any edge seen in the same clk; a half-received
      // write byte is simply dropped.
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      sout_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
        end

        CMD: if (rise) begin
          op_hi_d = sin_s;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            cnt_d = '0;
            if (opcode == READCMD || opcode == WRITECMD) begin
              is_read_d = (opcode == READCMD);
              state_d   = ADDR;
            end else begin
              bad_cmd_d = 1'b1;
              state_d   = IGNORE;
            end
          end
        end

        ADDR: if (rise) begin
          addr_d = addr_full;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d     = '0;
            wr_lo_d   = 1'b0;
            lo_next_d = 1'b0;
            if (is_read_q) begin
              // First byte is fetched during the dummy phase.
              mem_re_d   = 1'b1;
              mem_addr_d = addr_full;
            end
            if (dummy_n == 8'd0) state_d = is_read_q ? RDATA : WDATA;
            else                 state_d = DUMMY;
          end
        end

        DUMMY: if (rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == dummy_n) begin
            cnt_d   = '0;
            state_d = is_read_q ? RDATA : WDATA;
          end
        end

        // Enters with spi_oe low; the first falling edge turns the bus around
        // and presents the prefetched high nibble.
        RDATA: if (fall) begin
          if (spi_oe && lo_next_q) begin
            sout_d    = cur_lo_q;
            lo_next_d = 1'b0;
          end else begin
            oe_d       = 1'b1;
            sout_d     = prefetch_q[7:4];
            cur_lo_d   = prefetch_q[3:0];
            lo_next_d  = 1'b1;
            mem_re_d   = 1'b1;
            mem_addr_d = addr_q + 1'b1;
            addr_d     = addr_q + 1'b1;
          end
        end

        WDATA: if (rise) begin
          if (!wr_lo_q) begin
            wr_hi_d = sin_s;
            wr_lo_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {wr_hi_q, sin_s};
            mem_addr_d  = addr_q;
            addr_d      = addr_q + 1'b1;
            wr_lo_d     = 1'b0;
          end
        end

        IGNORE: ;

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpimem_target.sv
// Testbench for qpimem_target: drives QPI transactions from a vector table,
// models the byte-wide backing memory, and scoreboards every memory strobe.
module tb_qpimem_target;

  localparam int HALF     = 6;     // clk cycles per spi_clk half period
  localparam int AW       = 17;
  localparam int RD_DUMMY = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_clk;
  logic          spi_ncs;
  logic [3:0]    spi_sin;
  logic [3:0]    spi_sout;
  logic          spi_oe;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          bad_cmd;
  logic          mem_init;

  qpimem_target dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_ncs   (spi_ncs),
    .spi_sin   (spi_sin),
    .spi_sout  (spi_sout),
    .spi_oe    (spi_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .bad_cmd   (bad_cmd)
  );

  always #5 clk = ~clk;

  // Backing memory: registered read, one clk latency.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
      mem[17'h00100] <= 8'h11;
      mem[17'h00101] <= 8'h22;
      mem[17'h00102] <= 8'h33;
      mem[17'h00103] <= 8'h44;
      mem[17'h1FFFF] <= 8'h5C;
      mem[17'h00000] <= 8'h3D;
      mem_rdata      <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  int oe_cycles = 0;
  int bad_cycles = 0;
  int unexp_cnt = 0;
  int overlap_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } mem_ev_t;

  mem_ev_t exp_q[$];
  mem_ev_t mon_ev;

  always @(negedge clk) begin
    if (spi_oe)            oe_cycles++;
    if (bad_cmd)           bad_cycles++;
    if (mem_we && mem_re)  overlap_cnt++;
    if (mem_we || mem_re) begin
      if (exp_q.size() == 0) begin
        unexp_cnt++;
      end else begin
        mon_ev = exp_q.pop_front();
        check("mem_we_vs_re", 32'(mem_we), 32'(mon_ev.we));
        check("mem_addr", 32'(mem_addr), 32'(mon_ev.addr));
        if (mon_ev.we) check("mem_wdata", 32'(mem_wdata), 32'(mon_ev.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Bus driver
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int i);
    logic [31:0] s;
    s = w >> (28 - 4 * i);
    return s[3:0];
  endfunction

  // One bus clock: drop spi_clk, drive the nibble, sample what the target
  // shows just before the rising edge, raise spi_clk and leave it high.
  task automatic bus_nib(input logic [3:0] n, output logic [3:0] got, output logic oe_now);
    spi_clk = 1'b0;
    spi_sin = n;
    wait_clk(HALF);
    got    = spi_sout;
    oe_now = spi_oe;
    spi_clk = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic start_txn(input string tag);
    spi_ncs = 1'b0;
    wait_clk(HALF);
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
  endtask

  // Deselect together with the final falling edge, so no trailing edge is
  // seen while selected.
  task automatic end_txn(input string tag);
    spi_ncs = 1'b1;
    spi_clk = 1'b0;
    spi_sin = 4'h0;
    wait_clk(3);
    check({tag, "_oe_off"}, 32'(spi_oe), 32'd0);
    wait_clk(6);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
    logic [3:0] got;
    logic       oe_now;
    bus_nib(op[7:4], got, oe_now);
    bus_nib(op[3:0], got, oe_now);
    for (int i = 0; i < 6; i++) bus_nib(4'(addr >> (20 - 4 * i)), got, oe_now);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef enum {K_RD, K_WR, K_BAD} kind_t;

  typedef struct {
    kind_t       kind;
    logic [7:0]  op;
    logic [23:0] addr;
    int          n_nib;   // data nibbles (read/write) or trailing clocks (bad)
    logic [31:0] nibs;    // write nibbles or expected read nibbles, first at [31:28]
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  task automatic run_vec(input vec_t v, input int idx);
    string         tag;
    logic [AW-1:0] a;
    logic [3:0]    got;
    logic          oe_now;
    mem_ev_t       e;
    int            o0, b0, u0;
    tag = $sformatf("v%0d", idx);
    a   = v.addr[AW-1:0];
    o0  = oe_cycles;
    b0  = bad_cycles;
    u0  = unexp_cnt;

    // Expected memory strobes: a read fetches one byte ahead of the bus.
    if (v.kind == K_RD) begin
      for (int i = 0; i <= v.n_nib / 2; i++) begin
        e.we = 1'b0; e.addr = a + AW'(i); e.data = 8'h00;
        exp_q.push_back(e);
      end
    end else if (v.kind == K_WR) begin
      for (int i = 0; i < v.n_nib / 2; i++) begin
        e.we = 1'b1; e.addr = a + AW'(i);
        e.data = {nib_of(v.nibs, 2 * i), nib_of(v.nibs, 2 * i + 1)};
        exp_q.push_back(e);
      end
    end

    start_txn(tag);
    if (v.kind == K_BAD) begin
      bus_nib(v.op[7:4], got, oe_now);
      bus_nib(v.op[3:0], got, oe_now);
      for (int i = 0; i < v.n_nib; i++) bus_nib(4'h0, got, oe_now);
    end else begin
      send_hdr(v.op, v.addr);
      if (v.kind == K_RD) begin
        for (int d = 0; d < RD_DUMMY; d++) begin
          bus_nib(4'hF, got, oe_now);
          check({tag, "_dummy_oe"}, 32'(oe_now), 32'd0);
        end
        for (int i = 0; i < v.n_nib; i++) begin
          bus_nib(4'h0, got, oe_now);
          check({tag, "_rd_oe"}, 32'(oe_now), 32'd1);
          check($sformatf("%s_rd_nib%0d", tag, i), 32'(got), 32'(nib_of(v.nibs, i)));
        end
      end else begin
        for (int i = 0; i < v.n_nib; i++) bus_nib(nib_of(v.nibs, i), got, oe_now);
      end
    end
    end_txn(tag);

    check({tag, "_sb_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({tag, "_sb_unexpected"}, 32'(unexp_cnt - u0), 32'd0);
    check({tag, "_bad_cmd_cycles"}, 32'(bad_cycles - b0), (v.kind == K_BAD) ? 32'd1 : 32'd0);
    if (v.kind != K_RD) check({tag, "_oe_quiet"}, 32'(oe_cycles - o0), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] got;
    logic       oe_now;
    mem_ev_t    e;
    logic [3:0] rst_exp [3];

    rst      = 1'b1;
    mem_init = 1'b1;
    spi_ncs  = 1'b1;
    spi_clk  = 1'b0;
    spi_sin  = 4'h0;
    wait_clk(4);

    check("reset_spi_oe",    32'(spi_oe),    32'd0);
    check("reset_spi_sout",  32'(spi_sout),  32'd0);
    check("reset_mem_we",    32'(mem_we),    32'd0);
    check("reset_mem_re",    32'(mem_re),    32'd0);
    check("reset_mem_addr",  32'(mem_addr),  32'd0);
    check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_bad_cmd",   32'(bad_cmd),   32'd0);
    rst      = 1'b0;
    mem_init = 1'b0;
    wait_clk(4);

    vecs[0]  = '{kind: K_RD,  op: 8'hEB, addr: 24'h000100, n_nib: 8,  nibs: 32'h1122_3344};
    vecs[1]  = '{kind: K_WR,  op: 8'h38, addr: 24'h000200, n_nib: 8,  nibs: 32'hABCD_EF01};
    vecs[2]  = '{kind: K_RD,  op: 8'hEB, addr: 24'h000200, n_nib: 8,  nibs: 32'hABCD_EF01};
    vecs[3]  = '{kind: K_BAD, op: 8'h9F, addr: 24'h000000, n_nib: 10, nibs: 32'h0};
    vecs[4]  = '{kind: K_RD,  op: 8'hEB, addr: 24'h000100, n_nib: 4,  nibs: 32'h1122_0000};
    vecs[5]  = '{kind: K_WR,  op: 8'h38, addr: 24'h000010, n_nib: 3,  nibs: 32'h5A70_0000};
    vecs[6]  = '{kind: K_RD,  op: 8'hEB, addr: 24'h000010, n_nib: 2,  nibs: 32'h5A00_0000};
    vecs[7]  = '{kind: K_RD,  op: 8'hEB, addr: 24'h01FFFF, n_nib: 4,  nibs: 32'h5C3D_0000};
    vecs[8]  = '{kind: K_RD,  op: 8'hEB, addr: 24'hFE0100, n_nib: 4,  nibs: 32'h1122_0000};
    vecs[9]  = '{kind: K_WR,  op: 8'h38, addr: 24'h01FFFF, n_nib: 4,  nibs: 32'h9687_0000};
    vecs[10] = '{kind: K_RD,  op: 8'hEB, addr: 24'h01FFFF, n_nib: 4,  nibs: 32'h9687_0000};

    for (int v = 0; v < NVEC; v++) run_vec(vecs[v], v);

    // Reset in the middle of a read data phase.
    rst_exp[0] = 4'h1; rst_exp[1] = 4'h1; rst_exp[2] = 4'h2;
    for (int i = 0; i < 3; i++) begin
      e.we = 1'b0; e.addr = AW'(17'h00100 + i); e.data = 8'h00;
      exp_q.push_back(e);
    end
    start_txn("rstseq");
    send_hdr(8'hEB, 24'h000100);
    for (int d = 0; d < RD_DUMMY; d++) bus_nib(4'hF, got, oe_now);
    for (int i = 0; i < 3; i++) begin
      bus_nib(4'h0, got, oe_now);
      check($sformatf("rstseq_rd_nib%0d", i), 32'(got), 32'(rst_exp[i]));
    end
    rst = 1'b1;
    wait_clk(1);
    check("rstseq_oe_next_clk", 32'(spi_oe), 32'd0);
    check("rstseq_busy", 32'(busy), 32'd0);
    rst     = 1'b0;
    spi_ncs = 1'b1;
    spi_clk = 1'b0;
    spi_sin = 4'h0;
    wait_clk(10);
    check("rstseq_oe_stays_off", 32'(spi_oe), 32'd0);
    check("rstseq_sb_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    run_vec(vecs[0], 100);

    check("we_re_overlap_cycles", 32'(overlap_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
